// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand-fetch stage feeding alu_32bitex (8-entry regfile, bypass, 1-cycle pipeline register)
// Ports: clk/rst_n (async active-low); in_valid/in_ready handshake with in_rs1, in_rs2, in_rd,
// in_use_imm, in_imm, in_operation, in_mode; registered op1, op2, operation, mode, out_rd with
// out_valid/out_ready; writeback wb_en, wb_addr, wb_data.
// Optional: define ALU_OPERAND_SCOREBOARD_EN for a per-register busy scoreboard that blocks hazards.
module alu_operand_stage #(
  parameter int LENGTH = 32,
  parameter int REG_COUNT = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_use_imm,
  input  logic [LENGTH-1:0] in_imm,
  input  logic [2:0]        in_operation,
  input  logic              in_mode,
  output logic [LENGTH-1:0] op1,
  output logic [LENGTH-1:0] op2,
  output logic [2:0]        operation,
  output logic              mode,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [LENGTH-1:0] wb_data
);
  logic [LENGTH-1:0] regs [REG_COUNT];
  logic              accept;
  logic              hazard;
  function automatic logic [LENGTH-1:0] read_op(input logic [ADDR_W-1:0] s);
    return s == '0 ? '0 : (wb_en && wb_addr == s) ? wb_data : regs[s];
  endfunction
`ifdef ALU_OPERAND_SCOREBOARD_EN
  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_m;
  logic [REG_COUNT-1:0] one;
  // a writeback this cycle releases its register before the hazard test, so the bypass can be used
  always_comb begin
    one = 1;
    busy_m = busy & ~(wb_en ? one << wb_addr : '0);
    hazard = busy_m[in_rs1] || (!in_use_imm && busy_m[in_rs2]) || busy_m[in_rd];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_m | ((accept && in_rd != '0) ? one << in_rd : '0);
`else
  assign hazard = 1'b0;
`endif
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != '0) regs[wb_addr] <= wb_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op1 <= '0;
      op2 <= '0;
      operation <= '0;
      mode <= 1'b0;
      out_rd <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      op1 <= read_op(in_rs1);
      op2 <= in_use_imm ? in_imm : read_op(in_rs2);
      operation <= in_operation;
      mode <= in_mode;
      out_rd <= in_rd;
      out_valid <= 1'b1;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: randomized and directed check of alu_operand_stage against a behavioural model
module tb_alu_operand_stage;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_use_imm = 0, in_mode = 0, mode, out_valid, out_ready = 0, wb_en = 0;
  logic [2:0] in_rs1 = 0, in_rs2 = 0, in_rd = 0, in_operation = 0, operation, out_rd, wb_addr = 0;
  logic [31:0] in_imm = 0, op1, op2, wb_data = 0;
  int errs = 0, checks = 0;
  logic [31:0] m_reg [8];
  logic [31:0] m_op1, m_op2;
  logic [2:0] m_opn, m_rd;
  logic m_mode, m_valid;
  logic [7:0] m_busy;
  always #5 clk = ~clk;
  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_rd(in_rd), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_operation(in_operation), .in_mode(in_mode), .op1(op1), .op2(op2), .operation(operation),
    .mode(mode), .out_rd(out_rd), .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_op1 = 0; m_op2 = 0; m_opn = 0; m_rd = 0; m_mode = 0; m_valid = 0; m_busy = 0;
  endtask
  function automatic logic [31:0] view(input logic [2:0] s);
    return s == 0 ? 32'h0 : (wb_en && wb_addr == s) ? wb_data : m_reg[s];
  endfunction
  task automatic step(input bit v, input logic [2:0] r1, r2, rd, input bit ui, input logic [31:0] imm,
                      input logic [2:0] opn, input bit md, input bit ordy, input bit we,
                      input logic [2:0] wa, input logic [31:0] wd);
    bit rdy, acc;
    logic [7:0] b;
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_use_imm = ui; in_imm = imm;
    in_operation = opn; in_mode = md; out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    rdy = !m_valid || ordy;
    b = m_busy;
    if (we) b[wa] = 0;
`ifdef ALU_OPERAND_SCOREBOARD_EN
    if (b[r1] || (!ui && b[r2]) || b[rd]) rdy = 0;
`endif
    chk("in_ready", in_ready, rdy);
    acc = v && rdy;
    if (acc) begin
      m_op1 = view(r1); m_op2 = ui ? imm : view(r2); m_opn = opn; m_mode = md; m_rd = rd; m_valid = 1;
    end else if (ordy) m_valid = 0;
    m_busy = b;
    if (acc && rd != 0) m_busy[rd] = 1;
    if (we && wa != 0) m_reg[wa] = wd;
    @(posedge clk); #1;
    chk("out_valid", out_valid, m_valid);
    chk("op1", op1, m_op1);
    chk("op2", op2, m_op2);
    chk("operation", operation, m_opn);
    chk("mode", mode, m_mode);
    chk("out_rd", out_rd, m_rd);
  endtask
  task automatic wb(input logic [2:0] a, input logic [31:0] d);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, a, d);
  endtask
  task automatic issue(input logic [2:0] r1, r2, rd, input bit ui, input logic [31:0] imm);
    step(1, r1, r2, rd, ui, imm, 3'b000, 0, 1, 0, 0, 0);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    rst_n = 1;
    @(posedge clk); #1;
    wb(3, 5); wb(4, 7);
    issue(3, 4, 0, 0, 0);
    chk("basic_op1", op1, 5); chk("basic_op2", op2, 7); chk("basic_valid", out_valid, 1);
    step(1, 2, 0, 0, 0, 0, 3'b101, 1, 1, 1, 2, 32'hDEAD_BEEF);
    chk("bypass_op1", op1, 32'hDEAD_BEEF);
    wb(0, 9);
    issue(0, 0, 0, 0, 0);
    chk("r0_op1", op1, 0);
    issue(3, 4, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 4, 3, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0);
    chk("stall_op1", op1, 5);
    step(1, 4, 3, 0, 0, 0, 3'b010, 0, 1, 0, 0, 0);
    chk("unstall_op1", op1, 7);
    for (int i = 1; i < 5; i++) step(1, 3, 4, 0, 0, 0, 3'(i), 0, 1, 0, 0, 0);
    chk("b2b_valid", out_valid, 1);
    wb(5, 100);
    issue(0, 5, 0, 1, 32'h3);
    chk("imm_op2", op2, 3);
    issue(0, 0, 6, 0, 0);
    issue(6, 0, 0, 0, 0);
`ifdef ALU_OPERAND_SCOREBOARD_EN
    chk("sb_blocked", out_valid, 0);
`else
    chk("sb_off_accept", out_valid, 1);
`endif
    step(1, 6, 0, 0, 0, 0, 0, 0, 1, 1, 6, 32'h1234);
    chk("sb_wb_op1", op1, 32'h1234);
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, 3'($urandom), 3'($urandom), 3'($urandom), $urandom_range(3) == 0,
           $urandom, 3'($urandom), 1'($urandom), $urandom_range(9) < 7, 1'($urandom), 3'($urandom), $urandom);
    wb(1, 32'h77);
    step(1, 1, 1, 0, 0, 0, 3'b111, 1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0); chk("rst_op1", op1, 0); chk("rst_op2", op2, 0);
    chk("rst_operation", operation, 0); chk("rst_mode", mode, 0); chk("rst_out_rd", out_rd, 0);
    model_reset();
    in_valid = 0;
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    for (int k = 1; k < 8; k++) begin
      issue(3'(k), 3'(k), 0, 0, 0);
      chk("post_rst_read", op1, 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
